// File: rtl/uart_tx_buffer_pkg.sv
// uart_tx_buffer_pkg: sequencer state encodings and UART_CTRL status bit map
package uart_tx_buffer_pkg;
  localparam logic [1:0] UTB_IDLE = 2'd0;
  localparam logic [1:0] UTB_SEND = 2'd1;
  localparam logic [1:0] UTB_BUSY = 2'd2;
  localparam int UART_CTRL_TX_NFULL = 0;
  localparam int UART_CTRL_OVF = 1;
  function automatic logic [1:0] utb_status(input logic full, input logic overflow);
    return {overflow, ~full};
  endfunction
endpackage

// File: rtl/uart_fifo_sync.sv
// uart_fifo_sync: byte FIFO with count-based occupancy and unreset distributed storage
module uart_fifo_sync #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  import uart_tx_buffer_pkg::*;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // storage write, no reset so it maps onto distributed RAM
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
  // pointers wrap naturally; occupancy is carried by count alone
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok & ~pop_ok) count <= count + 1'b1;
      else if (pop_ok & ~push_ok) count <= count - 1'b1;
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus SEND/READY sequencer feeding UART_TX_CTRL
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  input  logic          ovf_clr,
  input  logic          tx_ready,
  output logic          tx_send,
  output logic [7:0]    tx_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);
  logic [1:0] state;
  logic [7:0] fifo_dout;
  logic push, pop;
  assign push = wr_valid & ~full;
  assign pop = (state == UTB_IDLE) & ~empty & tx_ready;
  uart_fifo_sync #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(wr_data),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // sticky overflow on a write into a full FIFO; set beats clear
  always_ff @(posedge clk)
    if (reset) overflow <= 1'b0;
    else if (wr_valid & full) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  // sequencer: one SEND pulse per byte, then wait for the UART to go busy and return idle
  always_ff @(posedge clk)
    if (reset) begin
      state <= UTB_IDLE;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_send <= pop;
      if (pop) tx_data <= fifo_dout;
      case (state)
        UTB_IDLE: state <= pop ? UTB_SEND : UTB_IDLE;
        UTB_SEND: state <= tx_ready ? UTB_SEND : UTB_BUSY;
        UTB_BUSY: state <= tx_ready ? UTB_IDLE : UTB_BUSY;
        default:  state <= UTB_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed checks of the UART TX buffer against a UART_TX_CTRL model
module tb_uart_tx_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic ovf_clr = 1'b0;
  logic hold = 1'b0;
  logic tx_ready;
  logic tx_send;
  logic [7:0] tx_data;
  logic full, empty, overflow;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  logic [7:0] rx_q[$];

  always #10 clk = ~clk;

  uart_tx_buffer dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .ovf_clr(ovf_clr),
    .tx_ready(tx_ready),
    .tx_send(tx_send),
    .tx_data(tx_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow)
  );

  // UART_TX_CTRL model: READY drops the cycle after SEND, stays low 10 cycles
  assign tx_ready = (busy_cnt == 0) & ~hold;
  always @(posedge clk)
    if (tx_send) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;

  // record every byte handed to the UART
  always @(posedge clk)
    if (tx_send) rx_q.push_back(tx_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (rx_q.size() < n && t < 3000) begin
      tick();
      t++;
    end
    repeat (15) tick();
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL drain_count got %0d expected %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({count, empty, full, overflow, tx_send, tx_data} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d e=%b f=%b o=%b s=%b d=%h", count, empty, full, overflow, tx_send, tx_data);
    end
  endtask

  task automatic test_single();
    rx_q.delete();
    wr_valid = 1'b1;
    wr_data = 8'h41;
    tick();
    wr_valid = 1'b0;
    checks++;
    if ({count, empty, tx_send} !== {5'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_t1 got cnt=%0d e=%b s=%b expected 1 0 0", count, empty, tx_send);
    end
    tick();
    checks++;
    if ({tx_send, tx_data, count, empty} !== {1'b1, 8'h41, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_t2 got s=%b d=%h cnt=%0d e=%b expected 1 41 0 1", tx_send, tx_data, count, empty);
    end
    tick();
    checks++;
    if (tx_send !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got %b expected 0", tx_send);
    end
    drain(1);
    checks++;
    if (rx_q[0] !== 8'h41) begin
      errors++;
      $display("FAIL single_data got %h expected 41", rx_q[0]);
    end
  endtask

  task automatic test_burst();
    logic full_seen = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h30 + 8'(i);
      tick();
      full_seen |= full;
    end
    wr_valid = 1'b0;
    drain(16);
    checks++;
    if (full_seen !== 1'b0) begin
      errors++;
      $display("FAIL burst_full got 1 expected 0");
    end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'h30 + 8'(i)) begin
        errors++;
        $display("FAIL burst_order[%0d] got %h expected %h", i, rx_q[i], 8'h30 + 8'(i));
      end
    end
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      errors++;
      $display("FAIL burst_final got cnt=%0d e=%b expected 0 1", count, empty);
    end
  endtask

  task automatic test_overflow();
    rx_q.delete();
    hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h50 + 8'(i);
      tick();
    end
    checks++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      errors++;
      $display("FAIL ovf_full got f=%b cnt=%0d o=%b expected 1 16 0", full, count, overflow);
    end
    wr_data = 8'h99;
    tick();
    wr_valid = 1'b0;
    checks++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL ovf_drop got f=%b cnt=%0d o=%b expected 1 16 1", full, count, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b expected 0", overflow);
    end
  endtask

  task automatic test_pop_write();
    hold = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'hAA;
    tick();
    wr_valid = 1'b0;
    checks++;
    if ({count, overflow, tx_send, tx_data} !== {5'd15, 1'b1, 1'b1, 8'h50}) begin
      errors++;
      $display("FAIL popwr got cnt=%0d o=%b s=%b d=%h expected 15 1 1 50", count, overflow, tx_send, tx_data);
    end
    drain(16);
    for (int i = 0; i < 16 && i < rx_q.size(); i += 5) begin
      checks++;
      if (rx_q[i] !== 8'h50 + 8'(i)) begin
        errors++;
        $display("FAIL popwr_order[%0d] got %h expected %h", i, rx_q[i], 8'h50 + 8'(i));
      end
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset_busy();
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if ({count, tx_ready} !== {5'd5, 1'b0}) begin
      errors++;
      $display("FAIL rstbusy_pre got cnt=%0d rdy=%b expected 5 0", count, tx_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({count, empty, tx_send, tx_data} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rstbusy_post got cnt=%0d e=%b s=%b d=%h expected 0 1 0 00", count, empty, tx_send, tx_data);
    end
    repeat (25) tick();
    checks++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL rstbusy_sends got %0d expected 1", rx_q.size());
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    int t = 0;
    rx_q.delete();
    while (n < 40 && t < 5000) begin
      wr_valid = ($urandom_range(0, 2) != 0) && !full;
      wr_data = 8'(n * 7 + 3);
      tick();
      if (wr_valid) n++;
      t++;
    end
    wr_valid = 1'b0;
    drain(40);
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i * 7 + 3)) begin
        errors++;
        $display("FAIL wrap[%0d] got %h expected %h", i, rx_q[i], 8'(i * 7 + 3));
      end
    end
    checks++;
    if ({count, empty, overflow} !== {5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_final got cnt=%0d e=%b o=%b expected 0 1 0", count, empty, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_pop_write();
    test_reset_busy();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
